// File: rtl/dvi_pkg.sv
// Shared DVI pipeline definitions: default 640x480@60 timing, position widths
// and the sync/DE status bundle that travels alongside pixel data.
package dvi_pkg;

    localparam int H_ACTIVE = 640;
    localparam int H_FP     = 16;
    localparam int H_SYNC   = 96;
    localparam int H_BP     = 48;
    localparam int V_ACTIVE = 480;
    localparam int V_FP     = 10;
    localparam int V_SYNC   = 2;
    localparam int V_BP     = 33;

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int X_POS_W = 10;
    localparam int Y_POS_W = 10;

    // Output latency of the image generator; sync must be delayed to match it.
    localparam int GEN_PIPE_DLY = 2;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic de;
        logic sof;
    } sync_t;

endpackage

// File: rtl/sync_delay.sv
// Fixed-depth shift register for aligning side-band strobes with a pipelined
// data path; every stage resets to RESET_VAL so outputs are idle during reset.
module sync_delay #(
    parameter int                 DEPTH     = 2,
    parameter int                 WIDTH     = 4,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [DEPTH];

    // NOTE: every stage is reset, not just the last, otherwise stale status
    // from before reset would walk out of the line after release.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= RESET_VAL;
            end
        end else begin
            stage_q[0] <= d_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/video_timing_gen.sv
// Free-running raster scanner: registered x/y position for the image generator
// plus hsync/vsync/DE/SOF strobes delayed to line up with its colour output.
module video_timing_gen
    import dvi_pkg::*;
#(
    parameter int H_ACTIVE = dvi_pkg::H_ACTIVE,
    parameter int H_FP     = dvi_pkg::H_FP,
    parameter int H_SYNC   = dvi_pkg::H_SYNC,
    parameter int H_BP     = dvi_pkg::H_BP,
    parameter int V_ACTIVE = dvi_pkg::V_ACTIVE,
    parameter int V_FP     = dvi_pkg::V_FP,
    parameter int V_SYNC   = dvi_pkg::V_SYNC,
    parameter int V_BP     = dvi_pkg::V_BP,
    parameter bit H_POL    = 1'b0,
    parameter bit V_POL    = 1'b0,
    parameter int PIPE_DLY = dvi_pkg::GEN_PIPE_DLY,
    parameter int X_POS_W  = dvi_pkg::X_POS_W,
    parameter int Y_POS_W  = dvi_pkg::Y_POS_W
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    output logic [X_POS_W-1:0] x_o,
    output logic [Y_POS_W-1:0] y_o,
    output logic               hsync_o,
    output logic               vsync_o,
    output logic               de_o,
    output logic               sof_o
);

    localparam int LH_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int LV_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    if ((64'd1 << X_POS_W) < 64'(LH_TOTAL)) begin : g_x_width_check
        $error("X_POS_W is too narrow to hold H_TOTAL-1");
    end
    if ((64'd1 << Y_POS_W) < 64'(LV_TOTAL)) begin : g_y_width_check
        $error("Y_POS_W is too narrow to hold V_TOTAL-1");
    end
    if (PIPE_DLY < 1 || PIPE_DLY > 8) begin : g_dly_check
        $error("PIPE_DLY must be in 1..8");
    end

    localparam logic [X_POS_W-1:0] X_LAST     = X_POS_W'(LH_TOTAL - 1);
    localparam logic [X_POS_W-1:0] X_DE_END   = X_POS_W'(H_ACTIVE);
    localparam logic [X_POS_W-1:0] X_HS_START = X_POS_W'(H_ACTIVE + H_FP);
    localparam logic [X_POS_W-1:0] X_HS_END   = X_POS_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [Y_POS_W-1:0] Y_LAST     = Y_POS_W'(LV_TOTAL - 1);
    localparam logic [Y_POS_W-1:0] Y_DE_END   = Y_POS_W'(V_ACTIVE);
    localparam logic [Y_POS_W-1:0] Y_VS_START = Y_POS_W'(V_ACTIVE + V_FP);
    localparam logic [Y_POS_W-1:0] Y_VS_END   = Y_POS_W'(V_ACTIVE + V_FP + V_SYNC);

    localparam sync_t SYNC_IDLE = '{hsync: ~H_POL, vsync: ~V_POL, de: 1'b0, sof: 1'b0};

    logic [X_POS_W-1:0] x_q, x_d;
    logic [Y_POS_W-1:0] y_q, y_d;

    // NOTE: next-state logic assigns defaults first so no path leaves a
    // variable unassigned, which would infer a latch.
    always_comb begin
        x_d = x_q + 1'b1;
        y_d = y_q;
        if (x_q == X_LAST) begin
            x_d = '0;
            y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    logic  hs_act;
    logic  vs_act;
    sync_t status;
    sync_t status_dly;

    // vsync decodes on y only, so it switches at the start of a line.
    always_comb begin
        hs_act        = (x_q >= X_HS_START) && (x_q < X_HS_END);
        vs_act        = (y_q >= Y_VS_START) && (y_q < Y_VS_END);
        status.hsync  = hs_act ? H_POL : ~H_POL;
        status.vsync  = vs_act ? V_POL : ~V_POL;
        status.de     = (x_q < X_DE_END) && (y_q < Y_DE_END);
        status.sof    = (x_q == '0) && (y_q == '0);
    end

    sync_delay #(
        .DEPTH     (PIPE_DLY),
        .WIDTH     ($bits(sync_t)),
        .RESET_VAL (SYNC_IDLE)
    ) u_sync_delay (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .d_i    (status),
        .q_o    (status_dly)
    );

    assign x_o     = x_q;
    assign y_o     = y_q;
    assign hsync_o = status_dly.hsync;
    assign vsync_o = status_dly.vsync;
    assign de_o    = status_dly.de;
    assign sof_o   = status_dly.sof;

endmodule

// File: tb/tb_video_timing_gen.sv
// Bench for video_timing_gen: three instances (default 640x480, a medium mode
// with positive sync and PIPE_DLY=1, and a tiny mode) checked against a raster model.
module tb_video_timing_gen;

    typedef struct {
        int ha, hf, hs, hb, va, vf, vs, vb;
        bit hp, vp;
        int dly;
    } mode_t;

    logic       clk = 1'b0;
    logic [2:0] rst_n;
    logic [9:0] x   [3];
    logic [9:0] y   [3];
    logic       hs  [3];
    logic       vs  [3];
    logic       de  [3];
    logic       sof [3];
    int         k   [3];

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    video_timing_gen u_dut0 (
        .clk_i(clk), .rst_ni(rst_n[0]), .x_o(x[0]), .y_o(y[0]),
        .hsync_o(hs[0]), .vsync_o(vs[0]), .de_o(de[0]), .sof_o(sof[0])
    );

    video_timing_gen #(
        .H_ACTIVE(16), .H_FP(4), .H_SYNC(6), .H_BP(4),
        .V_ACTIVE(12), .V_FP(2), .V_SYNC(3), .V_BP(2),
        .H_POL(1'b1), .V_POL(1'b1), .PIPE_DLY(1)
    ) u_dut1 (
        .clk_i(clk), .rst_ni(rst_n[1]), .x_o(x[1]), .y_o(y[1]),
        .hsync_o(hs[1]), .vsync_o(vs[1]), .de_o(de[1]), .sof_o(sof[1])
    );

    video_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(2), .H_BP(2),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1)
    ) u_dut2 (
        .clk_i(clk), .rst_ni(rst_n[2]), .x_o(x[2]), .y_o(y[2]),
        .hsync_o(hs[2]), .vsync_o(vs[2]), .de_o(de[2]), .sof_o(sof[2])
    );

    // Edges seen since the last reset release: the scan index the counters should show.
    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst_n[d]) k[d] <= 0;
            else           k[d] <= k[d] + 1;
        end
    end

    function automatic mode_t get_mode(input int d);
        mode_t m;
        case (d)
            0:       m = '{640, 16, 96, 48, 480, 10, 2, 33, 1'b0, 1'b0, 2};
            1:       m = '{16, 4, 6, 4, 12, 2, 3, 2, 1'b1, 1'b1, 1};
            default: m = '{8, 2, 2, 2, 4, 1, 1, 1, 1'b0, 1'b0, 2};
        endcase
        return m;
    endfunction

    function automatic int htot(input mode_t m);
        return m.ha + m.hf + m.hs + m.hb;
    endfunction

    function automatic int vtot(input mode_t m);
        return m.va + m.vf + m.vs + m.vb;
    endfunction

    // Expected {hsync, vsync, de, sof} for scan index p; p < 0 means "not yet produced".
    function automatic logic [3:0] exp_stat(input mode_t m, input int p);
        int xx, yy;
        bit h_on, v_on, d_on, s_on;
        if (p < 0) return {~m.hp, ~m.vp, 2'b00};
        xx   = p % htot(m);
        yy   = (p / htot(m)) % vtot(m);
        h_on = (xx >= m.ha + m.hf) && (xx < m.ha + m.hf + m.hs);
        v_on = (yy >= m.va + m.vf) && (yy < m.va + m.vf + m.vs);
        d_on = (xx < m.ha) && (yy < m.va);
        s_on = (xx == 0) && (yy == 0);
        return {h_on ? m.hp : ~m.hp, v_on ? m.vp : ~m.vp, d_on, s_on};
    endfunction

    function automatic logic [3:0] act_stat(input int d);
        return {hs[d], vs[d], de[d], sof[d]};
    endfunction

    task automatic test_reset();
        mode_t m;
        rst_n = 3'b000;
        repeat (3) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                m = get_mode(d);
                n_tests++;
                if (x[d] !== 10'd0 || y[d] !== 10'd0 || act_stat(d) !== {~m.hp, ~m.vp, 2'b00}) begin
                    n_fail++;
                    $display("FAIL reset dut%0d: got x=%0d y=%0d st=%b, want x=0 y=0 st=%b",
                             d, x[d], y[d], act_stat(d), {~m.hp, ~m.vp, 2'b00});
                end
            end
        end
        rst_n = 3'b111;
    endtask

    task automatic test_default_line();
        mode_t m = get_mode(0);
        int sof_k = -1, de_start = -1, de_len = -1, hs_fall0 = -1, hs_fall1 = -1, hs_len = -1;
        int run = 0;
        logic p_de = 1'b0, p_hs = 1'b1;
        for (int c = 0; c < 1700; c++) begin
            @(negedge clk);
            n_tests++;
            if (x[0] !== 10'(k[0] % htot(m)) || y[0] !== 10'(k[0] / htot(m)) ||
                act_stat(0) !== exp_stat(m, k[0] - m.dly)) begin
                n_fail++;
                $display("FAIL line_scan k=%0d: got x=%0d y=%0d st=%b, want x=%0d y=%0d st=%b",
                         k[0], x[0], y[0], act_stat(0), k[0] % htot(m), k[0] / htot(m),
                         exp_stat(m, k[0] - m.dly));
            end
            if (sof[0] && sof_k < 0) sof_k = k[0];
            if (de[0] && !p_de && de_start < 0) de_start = k[0];
            if (de[0]) run++;
            if (!de[0] && p_de && de_len < 0) de_len = run;
            if (!de[0]) run = 0;
            if (!hs[0] && p_hs) begin
                if (hs_fall0 < 0) hs_fall0 = k[0];
                else if (hs_fall1 < 0) hs_fall1 = k[0];
            end
            if (hs[0] && !p_hs && hs_len < 0) hs_len = k[0] - hs_fall0;
            p_de = de[0];
            p_hs = hs[0];
        end
        n_tests++;
        if (sof_k !== 2) begin
            n_fail++; $display("FAIL first_sof: got cycle %0d, want 2", sof_k);
        end
        n_tests++;
        if (de_start !== 2 || de_len !== 640) begin
            n_fail++; $display("FAIL de_run: got start %0d len %0d, want start 2 len 640", de_start, de_len);
        end
        n_tests++;
        if (hs_fall0 !== 658 || hs_len !== 96) begin
            n_fail++; $display("FAIL hsync_pulse: got start %0d len %0d, want start 658 len 96", hs_fall0, hs_len);
        end
        n_tests++;
        if (hs_fall1 - hs_fall0 !== 800) begin
            n_fail++; $display("FAIL hsync_period: got %0d, want 800", hs_fall1 - hs_fall0);
        end
    endtask

    task automatic test_frame_wrap();
        mode_t m = get_mode(1);
        int ht = htot(m), vt = vtot(m);
        int sof0 = -1, sof1 = -1, de_cnt = 0, vs_rise = -1, vs_len = -1, vs_line = -1;
        logic [9:0] px = x[1], py = y[1];
        logic p_vs = vs[1];
        for (int c = 0; c < 3 * 570 + 20; c++) begin
            @(negedge clk);
            n_tests++;
            if (x[1] !== 10'(k[1] % ht) || y[1] !== 10'((k[1] / ht) % vt) ||
                act_stat(1) !== exp_stat(m, k[1] - m.dly)) begin
                n_fail++;
                $display("FAIL wrap_scan k=%0d: got x=%0d y=%0d st=%b, want st=%b",
                         k[1], x[1], y[1], act_stat(1), exp_stat(m, k[1] - m.dly));
            end
            if (px == 10'(ht - 1) && py == 10'(vt - 1)) begin
                n_tests++;
                if (x[1] !== 10'd0 || y[1] !== 10'd0) begin
                    n_fail++; $display("FAIL frame_wrap: got x=%0d y=%0d, want 0 0", x[1], y[1]);
                end
            end
            if (sof[1]) begin
                if (sof0 < 0) sof0 = k[1];
                else if (sof1 < 0) sof1 = k[1];
            end
            if (sof0 >= 0 && sof1 < 0 && de[1]) de_cnt++;
            if (vs[1] && !p_vs && vs_rise < 0) begin
                vs_rise = k[1];
                vs_line = (k[1] - m.dly) / ht % vt;
            end
            if (!vs[1] && p_vs && vs_rise >= 0 && vs_len < 0) vs_len = k[1] - vs_rise;
            px = x[1]; py = y[1]; p_vs = vs[1];
        end
        n_tests++;
        if (sof1 - sof0 !== ht * vt) begin
            n_fail++; $display("FAIL sof_period: got %0d, want %0d", sof1 - sof0, ht * vt);
        end
        n_tests++;
        if (de_cnt !== m.ha * m.va) begin
            n_fail++; $display("FAIL de_per_frame: got %0d, want %0d", de_cnt, m.ha * m.va);
        end
        n_tests++;
        if (vs_len !== m.vs * ht || vs_line !== m.va + m.vf || (vs_rise - m.dly) % ht !== 0) begin
            n_fail++;
            $display("FAIL vsync_pulse: got len %0d line %0d, want len %0d line %0d at x=0",
                     vs_len, vs_line, m.vs * ht, m.va + m.vf);
        end
    endtask

    task automatic test_small_mode();
        mode_t m = get_mode(2);
        int ht = htot(m), vt = vtot(m);
        int overlap = 0, max_x = 0, max_y = 0;
        for (int c = 0; c < 5 * ht * vt; c++) begin
            @(negedge clk);
            n_tests++;
            if (x[2] !== 10'(k[2] % ht) || y[2] !== 10'((k[2] / ht) % vt) ||
                act_stat(2) !== exp_stat(m, k[2] - m.dly)) begin
                n_fail++;
                $display("FAIL small_scan k=%0d: got x=%0d y=%0d st=%b, want st=%b",
                         k[2], x[2], y[2], act_stat(2), exp_stat(m, k[2] - m.dly));
            end
            if (de[2] && hs[2] == m.hp) overlap++;
            if (int'(x[2]) > max_x) max_x = int'(x[2]);
            if (int'(y[2]) > max_y) max_y = int'(y[2]);
        end
        n_tests++;
        if (overlap !== 0) begin
            n_fail++; $display("FAIL de_hsync_overlap: got %0d cycles, want 0", overlap);
        end
        n_tests++;
        if (max_x !== 13 || max_y !== 6) begin
            n_fail++; $display("FAIL small_extent: got max x=%0d y=%0d, want 13 6", max_x, max_y);
        end
    endtask

    task automatic test_mid_reset();
        mode_t m;
        int d, sof_k;
        for (int r = 0; r < 6; r++) begin
            d = (r < 2) ? 0 : int'($urandom_range(0, 2));
            m = get_mode(d);
            repeat ($urandom_range(20, 900)) @(posedge clk);
            #3;
            rst_n[d] = 1'b0;
            #1;
            n_tests++;
            if (x[d] !== 10'd0 || y[d] !== 10'd0 || act_stat(d) !== {~m.hp, ~m.vp, 2'b00}) begin
                n_fail++;
                $display("FAIL async_reset dut%0d: got x=%0d y=%0d st=%b, want x=0 y=0 st=%b",
                         d, x[d], y[d], act_stat(d), {~m.hp, ~m.vp, 2'b00});
            end
            repeat ($urandom_range(1, 4)) @(posedge clk);
            @(negedge clk);
            rst_n[d] = 1'b1;
            sof_k = -1;
            for (int c = 0; c < 60; c++) begin
                @(negedge clk);
                n_tests++;
                if (x[d] !== 10'(k[d] % htot(m)) || y[d] !== 10'((k[d] / htot(m)) % vtot(m)) ||
                    act_stat(d) !== exp_stat(m, k[d] - m.dly)) begin
                    n_fail++;
                    $display("FAIL restart_scan dut%0d k=%0d: got x=%0d y=%0d st=%b, want st=%b",
                             d, k[d], x[d], y[d], act_stat(d), exp_stat(m, k[d] - m.dly));
                end
                if (sof[d] && sof_k < 0) sof_k = k[d];
            end
            n_tests++;
            if (sof_k !== m.dly) begin
                n_fail++; $display("FAIL restart_sof dut%0d: got cycle %0d, want %0d", d, sof_k, m.dly);
            end
        end
    endtask

    initial begin
        rst_n = 3'b000;
        test_reset();
        test_default_line();
        test_frame_wrap();
        test_small_mode();
        test_mid_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
